// File: rtl/mem_pkg.sv
// mem_pkg: shared FSM encoding, owner codes and default widths for the memory port arbiter
package mem_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;
  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;
  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
endpackage

// File: rtl/starve_counter.sv
// starve_counter: saturating count of data grants made while fetch is waiting
module starve_counter #(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc_i,
  input  logic clr_i,
  output logic at_max_o
);
  localparam int W = $clog2(MAX + 1);
  localparam logic [W-1:0] MAX_C = W'(MAX);
  logic [W-1:0] cnt_q, cnt_d;
  // clear wins over increment; increment holds at MAX
  always_comb cnt_d = clr_i ? '0 : (inc_i && cnt_q != MAX_C) ? cnt_q + 1'b1 : cnt_q;
  // count register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign at_max_o = cnt_q == MAX_C;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between fetch and load/store, one transaction at a time
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_ready,
  output logic                i_rvalid,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic                d_ready,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                m_req,
  output logic                m_we,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  input  logic                m_ready,
  input  logic                m_rvalid,
  input  logic [DATA_W-1:0]   m_rdata,
  output logic                err
);
  state_e state_q, state_d;
  logic own_q, m_we_q, err_q, starved;
  logic [ADDR_W-1:0] m_addr_q;
  logic [DATA_W-1:0] m_wdata_q;
  logic [DATA_W/8-1:0] m_wstrb_q;
  logic idle, grant_data, grant_fetch, grant, store;
  assign idle        = rst && state_q == IDLE;
  assign grant_data  = idle && d_req && (!starved || !i_req);
  assign grant_fetch = idle && i_req && !grant_data;
  assign grant       = grant_data || grant_fetch;
  assign store       = grant_data && d_we;
  starve_counter #(.MAX(STARVE_MAX)) u_starve (
    .clk      (clk),
    .rst_n    (rst),
    .inc_i    (grant_data && i_req),
    .clr_i    (grant_fetch || (grant_data && !i_req)),
    .at_max_o (starved)
  );
  // FSM state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) state_q <= IDLE;
    else state_q <= state_d;
  // FSM next state: grant -> issue until accepted -> wait for the response
  always_comb
    state_d = (state_q == IDLE && grant)     ? ISSUE :
              (state_q == ISSUE && m_ready)  ? WAIT  :
              (state_q == WAIT && m_rvalid)  ? IDLE  : state_q;
  // FSM outputs: grants, memory request and response routing to the owner
  always_comb begin
    i_ready  = grant_fetch;
    d_ready  = grant_data;
    m_req    = state_q == ISSUE;
    i_rvalid = rst && state_q == WAIT && m_rvalid && own_q == OWN_I;
    d_rvalid = rst && state_q == WAIT && m_rvalid && own_q == OWN_D;
    i_rdata  = m_rdata;
    d_rdata  = m_rdata;
  end
  // latch the granted request so the memory sees stable fields while issuing
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      own_q     <= OWN_I;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      m_wstrb_q <= '0;
    end else if (grant) begin
      own_q     <= grant_data ? OWN_D : OWN_I;
      m_we_q    <= store;
      m_addr_q  <= grant_data ? d_addr : i_addr;
      m_wdata_q <= store ? d_wdata : '0;
      m_wstrb_q <= store ? d_wstrb : '0;
    end
  // a response outside WAIT is a protocol error that sticks until reset
  always_ff @(posedge clk or negedge rst)
    if (!rst) err_q <= 1'b0;
    else if (m_rvalid && state_q != WAIT) err_q <= 1'b1;
  assign m_we    = m_we_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign m_wstrb = m_wstrb_q;
  assign err     = err_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: table-driven and scoreboarded checks of the memory port arbiter
module tb_mem_port_arbiter;
  localparam int AW = 32, DW = 32, SW = DW / 8;
  logic clk = 1'b0, rst = 1'b1;
  logic i_req = 1'b0, d_req = 1'b0, d_we = 1'b0, m_ready = 1'b0, m_rvalid = 1'b0;
  logic [AW-1:0] i_addr = '0, d_addr = '0;
  logic [DW-1:0] d_wdata = '0, m_rdata = '0;
  logic [SW-1:0] d_wstrb = '0;
  logic i_ready, i_rvalid, d_ready, d_rvalid, m_req, m_we, err;
  logic [DW-1:0] i_rdata, d_rdata, m_wdata;
  logic [AW-1:0] m_addr;
  logic [SW-1:0] m_wstrb;
  always #5 clk = ~clk;
  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_ready(d_ready), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_ready(m_ready), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .err(err)
  );
  typedef struct {
    logic port;
    logic store;
    logic [DW-1:0] data;
  } exp_t;
  typedef struct {
    logic dport;
    logic we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] strb;
    int rdy;
    int lat;
    logic [DW-1:0] rdata;
    int rv;
  } vec_t;
  exp_t sb[$];
  bit glog[$];
  int tacc[$];
  int vecs = 0, miss = 0, n = 0;
  int rdy_cfg = 0, rv_cfg = 0, rdy_left = 0, rv_left = 0;
  logic resp_pend = 1'b0, spur = 1'b0, i_hold = 1'b0, d_hold = 1'b0, in_issue = 1'b0;
  logic [DW-1:0] resp_data = '0;
  int t_acc, t_mreq, t_rv, n_mreq, unstable;
  logic [AW-1:0] cap_addr;
  logic [DW-1:0] cap_wdata, cap_rdata;
  logic [SW-1:0] cap_strb;
  logic cap_we;
  function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
    return a == 32'h100 ? 32'hDEADBEEF : {a[15:0], ~a[15:0]};
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, n);
    end
  endtask
  task automatic cyc();
    logic acc, mq, ig, dg, aw, rv_now;
    logic [AW-1:0] aa;
    exp_t e;
    m_ready = m_req && rdy_left == 0;
    rv_now = resp_pend && rv_left == 0;
    m_rvalid = spur || rv_now;
    m_rdata = resp_data;
    #1;
    mq = m_req; acc = m_req && m_ready; aa = m_addr; aw = m_we;
    ig = i_ready; dg = d_ready;
    if (!rst && (i_ready || d_ready || i_rvalid || d_rvalid))
      chk("handshake_in_reset", {28'b0, i_ready, d_ready, i_rvalid, d_rvalid}, 32'h0);
    if (ig) begin
      glog.push_back(1'b0); tacc.push_back(n); t_acc = n;
      sb.push_back('{1'b0, 1'b0, mem_fn(i_addr)});
    end
    if (dg) begin
      glog.push_back(1'b1); tacc.push_back(n); t_acc = n;
      sb.push_back('{1'b1, d_we, d_we ? 32'h0 : mem_fn(d_addr)});
    end
    if (m_req) begin
      if (!in_issue) begin
        t_mreq = n; cap_addr = m_addr; cap_wdata = m_wdata; cap_strb = m_wstrb; cap_we = m_we;
      end else if ({m_addr, m_wdata, m_wstrb, m_we} !== {cap_addr, cap_wdata, cap_strb, cap_we}) unstable++;
      in_issue = 1'b1;
      n_mreq++;
    end
    if (acc) in_issue = 1'b0;
    if (i_rvalid || d_rvalid) begin
      t_rv = n;
      cap_rdata = i_rvalid ? i_rdata : d_rdata;
      if (sb.size() == 0) begin
        vecs++; miss++;
        $display("FAIL rvalid_unexpected: got i_rvalid=%0b d_rvalid=%0b want none (cycle %0d)", i_rvalid, d_rvalid, n);
      end else begin
        e = sb.pop_front();
        chk("rvalid_port", {30'b0, i_rvalid, d_rvalid}, e.port ? 32'd1 : 32'd2);
        if (!e.store) chk("rdata", cap_rdata, e.data);
      end
    end
    @(posedge clk);
    if (rv_now) resp_pend = 1'b0;
    else if (resp_pend && rv_left > 0) rv_left--;
    if (acc) begin
      resp_pend = 1'b1; rv_left = rv_cfg; rdy_left = rdy_cfg;
      resp_data = aw ? 32'h0 : mem_fn(aa);
    end else if (mq && rdy_left > 0) rdy_left--;
    n++;
    #1;
    if (ig && !i_hold) i_req = 1'b0;
    if (dg && !d_hold) d_req = 1'b0;
  endtask
  task automatic drain();
    int k = 0;
    while ((i_req || d_req || sb.size() != 0 || resp_pend || m_req) && k < 100) begin
      cyc();
      k++;
    end
    chk("drain_timeout", {31'b0, k < 100}, 32'd1);
  endtask
  task automatic rst_pulse();
    rst = 1'b0;
    sb.delete();
    resp_pend = 1'b0; in_issue = 1'b0;
    rdy_cfg = 0; rdy_left = 0; rv_cfg = 0; rv_left = 0;
    #2;
    rst = 1'b1;
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    vec_t tv[6];
    bit pat[10];
    bit pat5[5];
    int t0;
    tv[0] = '{1'b0, 1'b0, 32'h100,  32'h0,        4'h0, 0, 0, 32'hDEADBEEF, 2};
    tv[1] = '{1'b1, 1'b0, 32'h300,  32'h0,        4'h0, 1, 0, 32'h0300FCFF, 3};
    tv[2] = '{1'b1, 1'b1, 32'h200,  32'h12345678, 4'h3, 3, 0, 32'h0,        5};
    tv[3] = '{1'b0, 1'b0, 32'h4,    32'h0,        4'h0, 0, 2, 32'h0004FFFB, 4};
    tv[4] = '{1'b1, 1'b0, 32'hFFFC, 32'h0,        4'h0, 2, 1, 32'hFFFC0003, 5};
    tv[5] = '{1'b1, 1'b1, 32'h40,   32'hA5A55A5A, 4'hF, 0, 0, 32'h0,        2};
    pat = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    pat5 = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    rst = 1'b0;
    i_req = 1'b1; d_req = 1'b1; i_addr = 32'h100; d_addr = 32'h300;
    cyc(); cyc();
    #1;
    chk("rst_handshake", {28'b0, i_ready, d_ready, i_rvalid, d_rvalid}, 32'h0);
    chk("rst_m_ctl", {29'b0, m_req, m_we, err}, 32'h0);
    chk("rst_m_addr", m_addr, 32'h0);
    chk("rst_m_wdata", m_wdata, 32'h0);
    chk("rst_m_wstrb", {28'b0, m_wstrb}, 32'h0);
    i_req = 1'b0; d_req = 1'b0;
    rst = 1'b1;
    cyc();
    foreach (tv[k]) begin
      rdy_cfg = tv[k].rdy; rdy_left = tv[k].rdy; rv_cfg = tv[k].lat;
      glog.delete();
      t_acc = -1; t_mreq = -1; t_rv = -1; n_mreq = 0; unstable = 0;
      t0 = n;
      if (tv[k].dport) begin
        d_req = 1'b1; d_we = tv[k].we; d_addr = tv[k].addr; d_wdata = tv[k].wdata; d_wstrb = tv[k].strb;
      end else begin
        i_req = 1'b1; i_addr = tv[k].addr;
      end
      for (int c = 0; c < 20 && t_rv < 0; c++) cyc();
      chk($sformatf("v%0d_accept", k), t_acc - t0, 0);
      chk($sformatf("v%0d_mreq_start", k), t_mreq - t0, 1);
      chk($sformatf("v%0d_rvalid_at", k), t_rv - t0, tv[k].rv);
      chk($sformatf("v%0d_mreq_len", k), n_mreq, tv[k].rdy + 1);
      chk($sformatf("v%0d_stable", k), unstable, 0);
      chk($sformatf("v%0d_m_addr", k), cap_addr, tv[k].addr);
      chk($sformatf("v%0d_m_we", k), {31'b0, cap_we}, {31'b0, tv[k].we});
      chk($sformatf("v%0d_m_wstrb", k), {28'b0, cap_strb}, tv[k].we ? {28'b0, tv[k].strb} : 32'h0);
      if (tv[k].we) chk($sformatf("v%0d_m_wdata", k), cap_wdata, tv[k].wdata);
      else chk($sformatf("v%0d_rdata", k), cap_rdata, tv[k].rdata);
      chk($sformatf("v%0d_grants", k), glog.size(), 1);
      cyc();
      #1;
      chk($sformatf("v%0d_idle", k), {27'b0, m_req, i_ready, d_ready, i_rvalid, d_rvalid}, 32'h0);
      chk($sformatf("v%0d_err", k), {31'b0, err}, 32'h0);
      d_we = 1'b0;
    end
    rst_pulse();
    glog.delete(); tacc.delete();
    i_addr = 32'h100; d_addr = 32'h300; d_we = 1'b0;
    i_hold = 1'b1; d_hold = 1'b1; i_req = 1'b1; d_req = 1'b1;
    for (int c = 0; c < 80 && glog.size() < 10; c++) cyc();
    chk("cont_count", glog.size(), 10);
    for (int k = 0; k < 10 && k < glog.size(); k++) chk($sformatf("cont_grant%0d", k), {31'b0, glog[k]}, {31'b0, pat[k]});
    for (int k = 1; k < tacc.size() && k < 10; k++) chk($sformatf("cont_gap%0d", k), tacc[k] - tacc[k-1], 3);
    i_hold = 1'b0; d_hold = 1'b0;
    drain();
    rst_pulse();
    glog.delete();
    i_hold = 1'b1; i_req = 1'b1; i_addr = 32'h100;
    d_hold = 1'b1; d_req = 1'b1; d_addr = 32'h300;
    for (int c = 0; c < 40 && glog.size() < 3; c++) cyc();
    i_hold = 1'b0; i_req = 1'b0; d_hold = 1'b0; d_req = 1'b0;
    drain();
    chk("starve_pre_grants", glog.size(), 3);
    glog.delete();
    d_req = 1'b1; d_addr = 32'h304;
    drain();
    chk("starve_lone_grant", glog.size(), 1);
    glog.delete();
    i_hold = 1'b1; d_hold = 1'b1; i_req = 1'b1; d_req = 1'b1;
    for (int c = 0; c < 40 && glog.size() < 5; c++) cyc();
    chk("starve_post_count", glog.size(), 5);
    for (int k = 0; k < 5 && k < glog.size(); k++) chk($sformatf("starve_post%0d", k), {31'b0, glog[k]}, {31'b0, pat5[k]});
    i_hold = 1'b0; d_hold = 1'b0;
    drain();
    rst_pulse();
    chk("err_after_reset", {31'b0, err}, 32'h0);
    spur = 1'b1;
    cyc();
    spur = 1'b0;
    #1;
    chk("err_spurious", {31'b0, err}, 32'h1);
    cyc(); cyc(); cyc();
    #1;
    chk("err_sticky", {31'b0, err}, 32'h1);
    rst = 1'b0;
    #1;
    chk("err_cleared", {31'b0, err}, 32'h0);
    rst = 1'b1;
    cyc();
    rst_pulse();
    rv_cfg = 3;
    i_req = 1'b1; i_addr = 32'h100;
    cyc();
    cyc();
    #1;
    chk("rw_in_wait", {30'b0, m_req, resp_pend}, 32'h1);
    rst = 1'b0;
    #1;
    chk("rw_reset_ctl", {25'b0, m_req, m_we, i_ready, d_ready, i_rvalid, d_rvalid, err}, 32'h0);
    chk("rw_reset_addr", m_addr, 32'h0);
    sb.delete();
    cyc();
    rst = 1'b1;
    for (int c = 0; c < 10 && resp_pend; c++) cyc();
    #1;
    chk("rw_late_rvalid_seen", {31'b0, resp_pend}, 32'h0);
    chk("rw_err", {31'b0, err}, 32'h1);
    chk("rw_no_rvalid", {30'b0, i_rvalid, d_rvalid}, 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares one single-port memory between the core's instruction-fetch port and its load/store port. Data accesses win by default. A starvation counter forces a fetch grant after a bounded run of data grants. One transaction is outstanding at a time. The block sits between the core and the unified memory inside `top`.

## Interface
- `ADDR_W`, 32: address width (byte addresses).
- `DATA_W`, 32: data width; `DATA_W/8` strobe bits.
- `STARVE_MAX`, 4: maximum consecutive data grants while fetch waits (≥1).

- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `i_req` input 1: fetch request; held with `i_addr` until `i_ready`.
- `i_addr` input ADDR_W: fetch address.
- `i_ready` output 1: fetch request accepted this cycle.
- `i_rvalid` output 1: fetch data valid; one-cycle pulse.
- `i_rdata` output DATA_W: fetch data.
- `d_req` input 1: load/store request; held until `d_ready`.
- `d_we` input 1: 1 = store.
- `d_addr` input ADDR_W: load/store address.
- `d_wdata` input DATA_W: store data.
- `d_wstrb` input DATA_W/8: byte strobes.
- `d_ready` output 1: load/store request accepted this cycle.
- `d_rvalid` output 1: load data or store acknowledge; one-cycle pulse.
- `d_rdata` output DATA_W: load data.
- `m_req` output 1: memory request.
- `m_we` output 1: memory write.
- `m_addr` output ADDR_W: memory address.
- `m_wdata` output DATA_W: memory write data.
- `m_wstrb` output DATA_W/8: memory strobes.
- `m_ready` input 1: memory accepts `m_req` this cycle.
- `m_rvalid` input 1: memory response (read data or write ack).
- `m_rdata` input DATA_W: memory read data.
- `err` output 1: sticky protocol error flag.

## Operation
- FSM states:
  - IDLE: grant decision.
  - ISSUE: `m_req` held until `m_ready`.
  - WAIT: awaiting `m_rvalid`.
- Owner register `own` (0 = fetch, 1 = data) is loaded on each grant.
- IDLE:
  - Grant rule: if `d_req` and `starve_cnt` < STARVE_MAX, grant data. Otherwise, if `i_req`, grant fetch. Otherwise, if `d_req`, grant data.
  - The granted requester's `x_ready` = 1 combinationally in the same cycle.
  - On a grant, the request fields are latched into `m_*` registers and the FSM moves to ISSUE.
  - Stores force `m_wdata`/`m_wstrb` from the latched data port. Fetches drive `m_we` = 0 and `m_wstrb` = 0.
- ISSUE: `m_req` = 1 and the `m_*` outputs are stable. When `m_ready` = 1, move to WAIT.
- WAIT: when `m_rvalid` = 1, route it to the owner's port:
  - `x_rvalid` = 1 and `x_rdata` = `m_rdata`, both combinational, in the same cycle.
  - FSM returns to IDLE.
  - The other port's rvalid stays 0.
- `starve_cnt` (width clog2(STARVE_MAX+1)):
  - Data grant with `i_req` = 1: +1, saturating.
  - Data grant with `i_req` = 0: cleared.
  - Fetch grant: cleared.
- `err` is set by `m_rvalid` in IDLE or ISSUE. It is cleared only by reset.
- Simultaneous `m_rvalid` and a new request in WAIT: the new request is not accepted until the next cycle, which is IDLE.

## Timing
- Reset values:
  - FSM = IDLE; `own` = 0; `starve_cnt` = 0; `err` = 0.
  - `m_req`, `m_we` = 0; `m_addr`, `m_wdata`, `m_wstrb` = 0.
  - `i_ready`, `d_ready`, `i_rvalid`, `d_rvalid` = 0.
- Accept in cycle T. `m_req` = 1 from T+1.
- With `m_ready` in T+1 and `m_rvalid` in T+2, the earliest next accept is T+3. Single-transaction throughput is 1 per 3 cycles.
- `x_ready` and `x_rvalid` are never asserted during reset.
- Reset mid-transaction drops the transaction and returns to IDLE. A late `m_rvalid` after reset release sets `err`.

## Structure
- Shared package `mem_pkg`:
  - FSM state encoding: IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2.
  - Owner constants OWN_I / OWN_D.
  - Default ADDR_W/DATA_W.
- One natural sub-module: `starve_counter` (saturating counter with inc/clr, parameter MAX). Everything else stays in one module.

## Test plan
- Lone fetch, `i_addr` = 0x100; memory answers 0xDEADBEEF with 1-cycle ready and 1-cycle latency -> `i_ready` at T, `m_req` at T+1, `i_rvalid` with 0xDEADBEEF at T+2; `d_rvalid` stays 0.
- `i_req` and `d_req` both held continuously, STARVE_MAX = 4 -> grant order D,D,D,D,I,D,D,D,D,I.
- Store `d_addr` = 0x200, `d_wdata` = 0x12345678, `d_wstrb` = 4'b0011, with `m_ready` held low 3 cycles -> `m_*` stable for 4 cycles of `m_req`; `d_rvalid` on the ack; `i_ready` stays 0 throughout.
- Spurious `m_rvalid` in IDLE -> `err` = 1, remaining 1 until `rst` low.
- `rst` low during WAIT, then `m_rvalid` after release -> outputs at reset values, no `x_rvalid`, `err` = 1.
- Data grant with `i_req` = 0 after 3 starved grants -> counter cleared; the next contention runs 4 data grants before fetch.
